// File: rtl/fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_pkg
// Description : Shared decoder-bundle layout for the fetch buffer and decode.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_buffer_pkg;

    // Decoder bundle: {nempty, unknown, badv, exception, pc_next, pc, inst}
    localparam int WIDTH_FBUNDLE = 137;
    localparam int WIDTH_FBENTRY = 136;
    localparam int FB_NEMPTY     = 136;
    localparam int FB_UNKNOWN    = 135;
    localparam int FB_BADV_HI    = 134;
    localparam int FB_BADV_LO    = 103;
    localparam int FB_EXC_HI     = 102;
    localparam int FB_EXC_LO     = 96;
    localparam int FB_PCNEXT_HI  = 95;
    localparam int FB_PCNEXT_LO  = 64;
    localparam int FB_PC_HI      = 63;
    localparam int FB_PC_LO      = 32;
    localparam int FB_INST_HI    = 31;
    localparam int FB_INST_LO    = 0;

    // Stored entry: everything in the bundle except the nempty flag
    typedef struct packed {
        logic        unknown;
        logic [31:0] badv;
        logic [6:0]  exception;
        logic [31:0] pc_next;
        logic [31:0] pc;
        logic [31:0] inst;
    } fb_entry_t;

    // Empty slots present all zeros so decode sees nempty=0 and uop type 0
    function automatic logic [WIDTH_FBUNDLE-1:0] fb_bundle(input logic nempty, input fb_entry_t e);
        return nempty ? {1'b1, e} : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer_ram
// Description : DEPTH x 136-bit register file, two write ports at consecutive
//               addresses and two asynchronous read ports at consecutive
//               addresses. No reset: contents are qualified by the pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer_ram
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       we0_i,
    input  logic                       we1_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  fb_entry_t                  wdata0_i,
    input  fb_entry_t                  wdata1_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output fb_entry_t                  rdata0_o,
    output fb_entry_t                  rdata1_o
);

    localparam int AW = $clog2(DEPTH);

    fb_entry_t        mem_q [DEPTH];
    logic [AW-1:0]    waddr1;
    logic [AW-1:0]    raddr1;

    // Second port addresses wrap naturally modulo DEPTH
    assign waddr1 = waddr_i + AW'(1);
    assign raddr1 = raddr_i + AW'(1);

    // Slot0 writes at waddr, slot1 at waddr+1; the two never collide
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we0_i && (waddr_i == AW'(i))) begin
                mem_q[i] <= wdata0_i;
            end else if (we1_i && (waddr1 == AW'(i))) begin
                mem_q[i] <= wdata1_i;
            end
        end
    end

    assign rdata0_o = mem_q[raddr_i];
    assign rdata1_o = mem_q[raddr1];

endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : In-order instruction queue between fetch and the two decoders.
//               Accepts up to two instructions per cycle, presents the two
//               oldest as 137-bit decoder bundles, flushes on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [1:0]                in_valid,
    output logic                      in_ready,
    input  logic [63:0]               in_inst,
    input  logic [63:0]               in_pc,
    input  logic [63:0]               in_pc_next,
    input  logic [13:0]               in_exception,
    input  logic [63:0]               in_badv,
    input  logic [1:0]                in_unknown,
    output logic [WIDTH_FBUNDLE-1:0]  out_bundle0,
    output logic [WIDTH_FBUNDLE-1:0]  out_bundle1,
    input  logic [1:0]                out_accept
);

    localparam int             AW            = $clog2(DEPTH);
    localparam logic [AW:0]    CNT_READY_MAX = (AW+1)'(DEPTH - 2);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic          wr0, wr1;
    logic          nempty0, nempty1;
    logic          pop0, pop1;
    logic [AW:0]   push_n, pop_n;
    fb_entry_t     wdata0, wdata1, rdata0, rdata1;

    // Ready depends only on registered count, so there is no accept->ready path
    assign in_ready = (count_q <= CNT_READY_MAX);

    // in_valid=2'b10 decodes as no push; slot1 needs slot0
    assign wr0    = in_ready & in_valid[0];
    assign wr1    = in_ready & in_valid[0] & in_valid[1];
    assign push_n = (AW+1)'(wr0) + (AW+1)'(wr1);

    // out_accept=2'b10 decodes as no pop; slot1 pops only together with slot0
    assign nempty0 = (count_q >= (AW+1)'(1));
    assign nempty1 = (count_q >= (AW+1)'(2));
    assign pop0    = out_accept[0] & nempty0;
    assign pop1    = out_accept[1] & out_accept[0] & nempty1;
    assign pop_n   = (AW+1)'(pop0) + (AW+1)'(pop1);

    assign wdata0 = '{unknown:   in_unknown[0],
                      badv:      in_badv[31:0],
                      exception: in_exception[6:0],
                      pc_next:   in_pc_next[31:0],
                      pc:        in_pc[31:0],
                      inst:      in_inst[31:0]};
    assign wdata1 = '{unknown:   in_unknown[1],
                      badv:      in_badv[63:32],
                      exception: in_exception[13:7],
                      pc_next:   in_pc_next[63:32],
                      pc:        in_pc[63:32],
                      inst:      in_inst[63:32]};

    // Next pointer/count state; flush discards any same-cycle push and pop
    always_comb begin
        head_d  = head_q + pop_n[AW-1:0];
        tail_d  = tail_q + push_n[AW-1:0];
        count_d = count_q + push_n - pop_n;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and count registers; reset takes priority over flush
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    fetch_buffer_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk      (clk),
        .we0_i    (wr0),
        .we1_i    (wr1),
        .waddr_i  (tail_q),
        .wdata0_i (wdata0),
        .wdata1_i (wdata1),
        .raddr_i  (head_q),
        .rdata0_o (rdata0),
        .rdata1_o (rdata1)
    );

    // No bypass: a pushed entry shows up only after it lands in storage
    assign out_bundle0 = fb_bundle(nempty0, rdata0);
    assign out_bundle1 = fb_bundle(nempty1, rdata1);

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Scoreboard bench for fetch_buffer: a queue model of the
//               buffer predicts both bundles and in_ready every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     flush = 1'b0;
    logic [1:0]               in_valid = '0;
    logic                     in_ready;
    logic [63:0]              in_inst = '0;
    logic [63:0]              in_pc = '0;
    logic [63:0]              in_pc_next = '0;
    logic [13:0]              in_exception = '0;
    logic [63:0]              in_badv = '0;
    logic [1:0]               in_unknown = '0;
    logic [WIDTH_FBUNDLE-1:0] out_bundle0;
    logic [WIDTH_FBUNDLE-1:0] out_bundle1;
    logic [1:0]               out_accept = '0;

    int          checks = 0;
    int          errors = 0;
    fb_entry_t   sb_q[$];
    logic [31:0] npc;
    logic        armed = 1'b0;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .in_pc        (in_pc),
        .in_pc_next   (in_pc_next),
        .in_exception (in_exception),
        .in_badv      (in_badv),
        .in_unknown   (in_unknown),
        .out_bundle0  (out_bundle0),
        .out_bundle1  (out_bundle1),
        .out_accept   (out_accept)
    );

    always #5 clk = ~clk;

    // Illegal encodings and pointer invariants
    always @(posedge clk) begin
        if (armed && !rst) begin
            assert (in_valid != 2'b10) else $error("illegal in_valid 2'b10");
            assert (out_accept != 2'b10) else $error("illegal out_accept 2'b10");
            assert (dut.count_q <= (AW+1)'(DEPTH)) else $error("count overflow");
            if (dut.count_q != (AW+1)'(DEPTH))
                assert (dut.count_q[AW-1:0] == AW'(dut.tail_q - dut.head_q)) else $error("count/pointer skew");
            assert (!((dut.count_q > (AW+1)'(DEPTH-2)) && (dut.push_n != '0))) else $error("push while full");
        end
    end

    task automatic chk_eq(input string tag, input logic [WIDTH_FBUNDLE-1:0] obs,
                          input logic [WIDTH_FBUNDLE-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic fb_entry_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                     input logic [6:0] exc, input logic [31:0] badv);
        fb_entry_t e;
        e.unknown   = pc[3];
        e.badv      = badv;
        e.exception = exc;
        e.pc_next   = pc + 32'd4;
        e.pc        = pc;
        e.inst      = inst;
        return e;
    endfunction

    function automatic fb_entry_t mk_seq(input logic [31:0] pc);
        return mk(pc, {pc[15:0], ~pc[15:0]}, 7'h0, 32'h0);
    endfunction

    // One cycle: drive, check outputs against the model mid-cycle, advance model
    task automatic step(input logic [1:0] v, input logic [1:0] acc, input logic fl,
                        input fb_entry_t e0, input fb_entry_t e1, output int pushed);
        logic rdy;
        in_valid     = v;
        out_accept   = acc;
        flush        = fl;
        in_inst      = {e1.inst, e0.inst};
        in_pc        = {e1.pc, e0.pc};
        in_pc_next   = {e1.pc_next, e0.pc_next};
        in_exception = {e1.exception, e0.exception};
        in_badv      = {e1.badv, e0.badv};
        in_unknown   = {e1.unknown, e0.unknown};
        @(negedge clk);
        chk_eq("bundle0", out_bundle0, fb_bundle(sb_q.size() >= 1, (sb_q.size() >= 1) ? sb_q[0] : '0));
        chk_eq("bundle1", out_bundle1, fb_bundle(sb_q.size() >= 2, (sb_q.size() >= 2) ? sb_q[1] : '0));
        rdy = (sb_q.size() <= DEPTH - 2);
        chk_eq("in_ready", {136'b0, in_ready}, {136'b0, rdy});
        pushed = 0;
        if (fl) begin
            sb_q.delete();
        end else begin
            if (acc[0] && sb_q.size() >= 2 && acc[1]) begin
                void'(sb_q.pop_front());
                void'(sb_q.pop_front());
            end else if (acc[0] && sb_q.size() >= 1) begin
                void'(sb_q.pop_front());
            end
            if (rdy && v[0]) begin
                sb_q.push_back(e0);
                pushed = 1;
                if (v[1]) begin
                    sb_q.push_back(e1);
                    pushed = 2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Sequential-pc push helper
    task automatic auto_step(input logic [1:0] v, input logic [1:0] acc, input logic fl);
        int n;
        step(v, acc, fl, mk_seq(npc), mk_seq(npc + 32'd4), n);
        npc = npc + 32'(4 * n);
    endtask

    initial begin
        int         n;
        fb_entry_t  ea, eb;
        logic [1:0] vr, ar;

        // Reset with flush also high
        rst = 1'b1; flush = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; armed = 1'b1;
        chk_eq("reset_b0", out_bundle0, '0);
        chk_eq("reset_b1", out_bundle1, '0);
        chk_eq("reset_ready", {136'b0, in_ready}, {136'b0, 1'b1});

        // Two-wide push of known instructions
        ea = mk(32'h1c000000, 32'h02800421, 7'h0, 32'h0);
        eb = mk(32'h1c000004, 32'h02800842, 7'h0, 32'h0);
        step(2'b11, 2'b00, 1'b0, ea, eb, n);
        chk_eq("t2_pc0", {105'b0, out_bundle0[FB_PC_HI:FB_PC_LO]}, {105'b0, 32'h1c000000});
        chk_eq("t2_inst1", {105'b0, out_bundle1[FB_INST_HI:FB_INST_LO]}, {105'b0, 32'h02800842});
        chk_eq("t2_nempty", {135'b0, out_bundle1[FB_NEMPTY], out_bundle0[FB_NEMPTY]}, {135'b0, 2'b11});

        // Fill to full; further pushes dropped
        auto_step(2'b00, 2'b00, 1'b1);
        npc = 32'h1c000000;
        repeat (3) auto_step(2'b11, 2'b00, 1'b0);
        chk_eq("t3_ready6", {136'b0, in_ready}, {136'b0, 1'b1});
        auto_step(2'b11, 2'b00, 1'b0);
        chk_eq("t3_ready8", {136'b0, in_ready}, {136'b0, 1'b0});
        auto_step(2'b11, 2'b00, 1'b0);
        chk_eq("t3_pc0", {105'b0, out_bundle0[FB_PC_HI:FB_PC_LO]}, {105'b0, 32'h1c000000});

        // Steady state push 2 / pop 2 across pointer wrap
        repeat (20) auto_step(2'b11, 2'b11, 1'b0);

        // Exception entry forwarded verbatim
        auto_step(2'b00, 2'b00, 1'b1);
        ea = mk(32'h1c000100, 32'h0280dead, 7'h08, 32'h1c000002);
        step(2'b01, 2'b00, 1'b0, ea, mk_seq(32'h0), n);
        chk_eq("t5_exc", {130'b0, out_bundle0[FB_EXC_HI:FB_EXC_LO]}, {130'b0, 7'h08});
        chk_eq("t5_badv", {105'b0, out_bundle0[FB_BADV_HI:FB_BADV_LO]}, {105'b0, 32'h1c000002});
        chk_eq("t5_inst", {105'b0, out_bundle0[FB_INST_HI:FB_INST_LO]}, {105'b0, 32'h0280dead});

        // Flush at count=5 beats same-cycle push and pop
        auto_step(2'b00, 2'b00, 1'b1);
        auto_step(2'b11, 2'b00, 1'b0);
        auto_step(2'b11, 2'b00, 1'b0);
        auto_step(2'b01, 2'b00, 1'b0);
        auto_step(2'b11, 2'b11, 1'b1);
        chk_eq("t6_b0", out_bundle0, '0);
        chk_eq("t6_b1", out_bundle1, '0);
        chk_eq("t6_ready", {136'b0, in_ready}, {136'b0, 1'b1});
        auto_step(2'b01, 2'b00, 1'b0);
        auto_step(2'b00, 2'b00, 1'b0);

        // Randomised legal traffic
        for (int i = 0; i < 60; i++) begin
            vr = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
            ar = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11);
            auto_step(vr, ar, ($urandom_range(0, 19) == 0));
        end

        // Reset mid-stream drops everything
        auto_step(2'b11, 2'b00, 1'b0);
        rst = 1'b1; in_valid = 2'b00; out_accept = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        chk_eq("rst_mid_b0", out_bundle0, '0);
        auto_step(2'b11, 2'b01, 1'b0);
        auto_step(2'b00, 2'b11, 1'b0);
        auto_step(2'b00, 2'b00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
